crc_stream_append: RTL and testbench

CRC_STREAM_APPEND -- requirements
Module: crc_stream_append

---
 rtl/crc_stream_append.sv | 104 ++++++++++
 tb/tb_crc_stream_append.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_append.sv
// Byte-stream pass-through that appends a CRC (MSB-first, non-reflected) after each frame's last byte.
// One-cycle latency, full throughput; in_ready follows the output register's free slot and drops while CRC bytes go out.
module crc_stream_append #(
  parameter int                   CRC_WIDTH = 24,
  parameter logic [CRC_WIDTH-1:0] POLY      = 24'h864CFB,
  parameter logic [CRC_WIDTH-1:0] INIT      = 24'hB704CE,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic [CRC_WIDTH-1:0] crc_value,
  output logic                 crc_done
);

  localparam int         NB       = CRC_WIDTH / 8;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  typedef enum logic {PASS, APPEND} state_t;

  state_t               state;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] hold;
  logic [CRC_WIDTH-1:0] crc_upd;
  logic [2:0]           idx;
  logic                 out_free;
  logic                 in_fire;

  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [7:0]           d);
    logic [CRC_WIDTH-1:0] r;
    r = c ^ (CRC_WIDTH'(d) << (CRC_WIDTH - 8));
    for (int i = 0; i < 8; i++) begin
      r = r[CRC_WIDTH-1] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == PASS) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign crc_upd  = crc_byte(crc_reg, in_data);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= PASS;
      crc_reg   <= INIT;
      hold      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      crc_value <= '0;
      crc_done  <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      case (state)
        PASS: begin
          if (in_fire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            crc_reg   <= crc_upd;
            if (in_last) begin
              crc_value <= crc_upd ^ XOR_OUT;
              hold      <= crc_upd ^ XOR_OUT;
              crc_done  <= 1'b1;
              idx       <= '0;
              state     <= APPEND;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        APPEND: begin
          // Leaving APPEND as the final CRC byte is loaded lets the next frame's
          // first byte replace it on its own handshake, keeping the gap at NB cycles.
          if (out_free) begin
            out_data  <= hold[CRC_WIDTH-1 -: 8];
            hold      <= hold << 8;
            out_valid <= 1'b1;
            out_last  <= (idx == LAST_IDX);
            idx       <= idx + 3'd1;
            if (idx == LAST_IDX) begin
              idx     <= '0;
              crc_reg <= INIT;
              state   <= PASS;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_append.sv
// Randomized self-checking bench for crc_stream_append; expected streams come from a bitwise long-division CRC model.
module tb_crc_stream_append;

  logic        clock;
  logic        reset;
  logic        in_valid, a_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [23:0] crc_value;
  logic        crc_done;

  logic        rdy16, ov16, ol16, cd16;
  logic [7:0]  od16;
  logic [15:0] cv16;
  logic        rdy32, ov32, ol32, cd32;
  logic [7:0]  od32;
  logic [31:0] cv32;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;
  bit rand_ready = 0;

  logic [7:0] frame_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] got16_q[$];
  logic [8:0] got32_q[$];

  bit         stalled = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  crc_stream_append dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .crc_value(crc_value), .crc_done(crc_done)
  );

  crc_stream_append #(.CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0)) dut16 (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_ready(rdy16),
    .in_data(in_data), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .out_last(ol16), .crc_value(cv16), .crc_done(cd16)
  );

  crc_stream_append #(.CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'h0)) dut32 (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_ready(rdy32),
    .in_data(in_data), .in_last(in_last), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_last(ol32), .crc_value(cv32), .crc_done(cd32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: a byte counts when valid and ready are both seen mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (crc_done) done_cnt++;
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  always @(negedge clock) begin
    if (reset && ov16 && out_ready) got16_q.push_back({ol16, od16});
    if (reset && ov32 && out_ready) got32_q.push_back({ol32, od32});
  end

  function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                            input logic [31:0] init);
    logic [31:0] c, mask;
    logic        fb;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    c = init;
    foreach (frame_q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[w-1] ^ frame_q[i][b];
        c  = (c << 1) & mask;
        if (fb) c = c ^ poly;
      end
    end
    return c;
  endfunction

  function automatic void expect_frame(input logic [23:0] crc);
    foreach (frame_q[i]) exp_q.push_back({1'b0, frame_q[i]});
    exp_q.push_back({1'b0, crc[23:16]});
    exp_q.push_back({1'b0, crc[15:8]});
    exp_q.push_back({1'b1, crc[7:0]});
  endfunction

  function automatic void load_digits();
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
  endfunction

  task automatic send_frame(input int gap_pct, input bit partial, output int first_wait);
    int w;
    first_wait = 0;
    foreach (frame_q[i]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = (i == frame_q.size() - 1) && !partial;
      w = 0;
      forever begin
        @(negedge clock);
        if (in_ready === 1'b1) break;
        w++;
        if (w > 2000) break;
      end
      if (w > 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL in_ready_timeout: got in_ready=%b after %0d cycles, required 1", in_ready, w);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) first_wait = w;
      @(posedge clock); #1;
    end
  endtask

  task automatic drain(output bit ok);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clock); #1;
      t++;
    end
    repeat (10) @(posedge clock);
    #1;
    ok = (got_q.size() >= exp_q.size());
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; a_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data: got %h required 00", out_data); end
    if (crc_value !== 24'h0) begin miscompares++; $display("FAIL rst_crc_value: got %h required 000000", crc_value); end
    if (crc_done !== 1'b0) begin miscompares++; $display("FAIL rst_crc_done: got %b required 0", crc_done); end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_known_vector();
    int w; bit ok;
    out_ready = 1'b1; done_cnt = 0;
    load_digits();
    expect_frame(24'h21CF02);
    send_frame(0, 0, w);
    in_valid = 1'b0;
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL known_len: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL known_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors += 2;
    if (crc_value !== 24'h21CF02) begin miscompares++; $display("FAIL known_crc_value: got %h required 21cf02", crc_value); end
    if (done_cnt !== 1) begin miscompares++; $display("FAIL known_crc_done: got %0d pulses required 1", done_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_param_widths();
    logic [8:0] e16[$];
    logic [8:0] e32[$];
    out_ready = 1'b1;
    got16_q.delete(); got32_q.delete();
    load_digits();
    foreach (frame_q[i]) begin e16.push_back({1'b0, frame_q[i]}); e32.push_back({1'b0, frame_q[i]}); end
    e16.push_back(9'h029); e16.push_back(9'h1B1);
    e32.push_back(9'h003); e32.push_back(9'h076); e32.push_back(9'h0E6); e32.push_back(9'h1E7);
    foreach (frame_q[i]) begin
      a_valid = 1'b1; in_data = frame_q[i]; in_last = (i == 8);
      @(posedge clock); #1;
    end
    a_valid = 1'b0; in_last = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    vectors += 2;
    if (got16_q.size() != e16.size()) begin miscompares++; $display("FAIL w16_len: got %0d required %0d", got16_q.size(), e16.size()); end
    if (got32_q.size() != e32.size()) begin miscompares++; $display("FAIL w32_len: got %0d required %0d", got32_q.size(), e32.size()); end
    foreach (e16[i]) if (i < got16_q.size()) begin
      vectors++;
      if (got16_q[i] !== e16[i]) begin miscompares++; $display("FAIL w16_byte[%0d]: got %h required %h", i, got16_q[i], e16[i]); end
    end
    foreach (e32[i]) if (i < got32_q.size()) begin
      vectors++;
      if (got32_q[i] !== e32[i]) begin miscompares++; $display("FAIL w32_byte[%0d]: got %h required %h", i, got32_q[i], e32[i]); end
    end
    vectors += 2;
    if (cv16 !== 16'h29B1) begin miscompares++; $display("FAIL w16_crc_value: got %h required 29b1", cv16); end
    if (cv32 !== 32'h0376E6E7) begin miscompares++; $display("FAIL w32_crc_value: got %h required 0376e6e7", cv32); end
  endtask

  task automatic test_random_stall();
    int w; bit ok; logic [23:0] last_crc;
    done_cnt = 0; last_crc = '0;
    rand_ready = 1;
    for (int f = 0; f < 3; f++) begin
      frame_q.delete();
      for (int n = $urandom_range(1, 12); n > 0; n--) frame_q.push_back(8'($urandom));
      last_crc = 24'(crc_model(24, 32'h864CFB, 32'hB704CE));
      expect_frame(last_crc);
      send_frame(30, 0, w);
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    rand_ready = 0; out_ready = 1'b1;
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_len: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors += 2;
    if (crc_value !== last_crc) begin miscompares++; $display("FAIL rand_crc_value: got %h required %h", crc_value, last_crc); end
    if (done_cnt !== 3) begin miscompares++; $display("FAIL rand_crc_done: got %0d pulses required 3", done_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int w; bit ok;
    out_ready = 1'b1;
    frame_q.delete();
    for (int i = 0; i < 5; i++) frame_q.push_back(8'($urandom));
    send_frame(0, 1, w);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    got_q.delete(); exp_q.delete(); done_cnt = 0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
    @(posedge clock); #1;
    load_digits();
    expect_frame(24'h21CF02);
    send_frame(0, 0, w);
    in_valid = 1'b0;
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL abort_len: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL abort_crc_done: got %0d pulses required 1", done_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int w1, w2; bit ok;
    out_ready = 1'b1; done_cnt = 0;
    frame_q.delete();
    frame_q.push_back(8'h31);
    expect_frame(24'(crc_model(24, 32'h864CFB, 32'hB704CE)));
    send_frame(0, 0, w1);
    load_digits();
    expect_frame(24'h21CF02);
    send_frame(0, 0, w2);
    in_valid = 1'b0;
    vectors++;
    if (w2 !== 3) begin miscompares++; $display("FAIL b2b_gap: got in_ready low %0d cycles required 3", w2); end
    drain(ok);
    vectors++;
    if (!ok || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_len: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors += 2;
    if (crc_value !== 24'h21CF02) begin miscompares++; $display("FAIL b2b_crc_value: got %h required 21cf02", crc_value); end
    if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_crc_done: got %0d pulses required 2", done_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_param_widths();
    test_random_stall();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
